// File: rtl/user_mbox_rx_pkg.sv
// Shared types, address map entry and register layout for the user-domain RX mailbox.
// Also carries the standalone OBI subordinate request/response structs used as type defaults.
package user_mbox_rx_pkg;

  localparam int unsigned ObiIdWidth = 4;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [ObiIdWidth-1:0] aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic                  err;
    logic [ObiIdWidth-1:0] rid;
  } sbr_obi_rsp_t;

  localparam logic [31:0] UserBaseAddr       = 32'h2000_0000;
  localparam logic [31:0] UserMboxAddrOffset = UserBaseAddr + 32'h0000_1000;
  localparam logic [31:0] UserMboxAddrRange  = 32'h0000_1000;

  typedef enum int unsigned {
    UserError = 0,
    UserMbox  = 1
  } user_demux_outputs_e;

  localparam int unsigned NumUserDomainSubordinates = 2;

  typedef struct packed {
    int unsigned idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  // Slot 0 is the error subordinate and has no rule of its own.
  localparam addr_map_rule_t [NumUserDomainSubordinates-2:0] user_addr_map = '{
    '{idx:        int'(UserMbox),
      start_addr: UserMboxAddrOffset,
      end_addr:   UserMboxAddrOffset + UserMboxAddrRange}
  };

  localparam logic [11:0] MboxDataOffset   = 12'h000;
  localparam logic [11:0] MboxStatusOffset = 12'h004;
  localparam logic [11:0] MboxCtrlOffset   = 12'h008;

  function automatic logic [31:0] mbox_status(input logic [7:0] level, input logic udf,
                                              input logic ovf, input logic full,
                                              input logic empty);
    return {16'h0000, level, 4'h0, udf, ovf, full, empty};
  endfunction

endpackage

// File: rtl/user_mbox_fifo.sv
// Synchronous FIFO with flush; push/pop take effect on the clock edge, head is read combinationally.
// Overflowing pushes and underflowing pops are ignored; flush overrides both.
module user_mbox_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o,
  output logic [LvlW-1:0]  level_next_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o       = (level_q == LvlW'(Depth));
  assign empty_o      = (level_q == '0);
  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign head_o       = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      level_d = level_q + LvlW'(do_push) - LvlW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/user_mbox_rx.sv
// OBI register front-end of the RX mailbox: DATA pops, STATUS/CTRL, threshold interrupt.
// gnt=req with rvalid one cycle later; the stream port stalls only on full or a clear write.
module user_mbox_rx
  import user_mbox_rx_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter type obi_req_t = sbr_obi_req_t,
  parameter type obi_rsp_t = sbr_obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  input  logic [31:0] push_data_i,
  input  logic        push_valid_i,
  output logic        push_ready_o,
  output logic        irq_o
);

  localparam int unsigned LvlW = $clog2(Depth) + 1;

  logic [9:0]            word_off;
  logic                  is_data, is_status, is_ctrl;
  logic                  data_rd, clear_wr, ctrl_wr, push;
  logic [31:0]           head;
  logic                  full, empty;
  logic [LvlW-1:0]       level, level_next;
  logic [7:0]            level8, level8_next;

  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [ObiIdWidth-1:0] rid_q, rid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [7:0]            thr_q, thr_d;
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic                  unused_bits;

  assign word_off  = obi_req_i.addr[11:2];
  assign is_data   = (word_off == MboxDataOffset[11:2]);
  assign is_status = (word_off == MboxStatusOffset[11:2]);
  assign is_ctrl   = (word_off == MboxCtrlOffset[11:2]);

  assign data_rd  = obi_req_i.req && !obi_req_i.we && is_data;
  assign ctrl_wr  = obi_req_i.req && obi_req_i.we && is_ctrl;
  assign clear_wr = ctrl_wr && obi_req_i.wdata[9];

  assign push_ready_o = !full && !clear_wr;
  assign push         = push_valid_i && push_ready_o;

  assign level8      = 8'(level);
  assign level8_next = 8'(level_next);

  assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[31:12], obi_req_i.addr[1:0],
                         obi_req_i.wdata[31:10]};

  user_mbox_fifo #(
    .Depth (Depth),
    .Width (32)
  ) i_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (clear_wr),
    .push_i       (push),
    .push_data_i  (push_data_i),
    .pop_i        (data_rd),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .level_next_o (level_next)
  );

  always_comb begin
    rvalid_d = obi_req_i.req;
    rdata_d  = '0;
    err_d    = 1'b0;
    rid_d    = obi_req_i.req ? obi_req_i.aid : '0;
    thr_d    = thr_q;
    irq_en_d = irq_en_q;

    if (obi_req_i.req) begin
      if (is_data) begin
        if (obi_req_i.we) err_d = 1'b1;
        else if (!empty) rdata_d = head;
      end else if (is_status) begin
        if (obi_req_i.we) err_d = 1'b1;
        else rdata_d = mbox_status(level8, udf_q, ovf_q, full, empty);
      end else if (is_ctrl) begin
        if (!obi_req_i.we) rdata_d = {23'h0, irq_en_q, thr_q};
      end else begin
        err_d = 1'b1;
      end
    end

    if (ctrl_wr) begin
      thr_d    = obi_req_i.wdata[7:0];
      irq_en_d = obi_req_i.wdata[8];
    end

    // A clear wins over any flag set in the same cycle.
    ovf_d = clear_wr ? 1'b0 : (ovf_q || (push_valid_i && full));
    udf_d = clear_wr ? 1'b0 : (udf_q || (data_rd && empty));

    irq_d = irq_en_d && (thr_d != 8'h00) && (level8_next >= thr_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rid_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      thr_q    <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rid_q    <= rid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      thr_q    <= thr_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
    obi_rsp_o.rid    = rid_q;
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_user_mbox_rx.sv
// Bench for user_mbox_rx: queue-based reference model compared every cycle, plus literal spot checks.
module tb_user_mbox_rx;
  import user_mbox_rx_pkg::*;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;
  logic [31:0]  pd;
  logic         pv, pr, irq;

  user_mbox_rx #(.Depth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_req_i    (req),
    .obi_rsp_o    (rsp),
    .push_data_i  (pd),
    .push_valid_i (pv),
    .push_ready_o (pr),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          m_ovf, m_udf, m_en;
  logic [7:0]  m_thr;
  logic [31:0] e_rdata, e_rid;
  bit          e_rvalid, e_err, e_irq, e_gnt, e_rdy;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit clr_now();
    return req.req && req.we && (req.addr[11:2] == 10'd2) && req.wdata[9];
  endfunction

  function automatic void set_comb_exp();
    e_gnt = req.req;
    e_rdy = (mq.size() != DEPTH) && !clr_now();
  endfunction

  // Advances the model by one clock edge using the inputs presently driven.
  function automatic void model_step();
    logic [9:0] off;
    bit full, empty, clr, udf_set;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_en = 0; m_thr = '0;
      e_rvalid = 0; e_rdata = '0; e_err = 0; e_rid = '0; e_irq = 0;
      return;
    end
    off     = req.addr[11:2];
    full    = (mq.size() == DEPTH);
    empty   = (mq.size() == 0);
    clr     = clr_now();
    udf_set = 0;
    e_rvalid = req.req;
    e_rdata  = '0;
    e_err    = 0;
    e_rid    = req.req ? 32'(req.aid) : '0;
    if (req.req) begin
      case (off)
        10'd0: if (req.we) e_err = 1;
               else if (!empty) e_rdata = mq.pop_front();
               else udf_set = 1;
        10'd1: if (req.we) e_err = 1;
               else e_rdata = {16'h0, 8'(mq.size()), 4'h0, m_udf, m_ovf, full, empty};
        10'd2: if (req.we) begin m_thr = req.wdata[7:0]; m_en = req.wdata[8]; end
               else e_rdata = {23'h0, m_en, m_thr};
        default: e_err = 1;
      endcase
    end
    if (pv && full && !clr) m_ovf = 1;
    if (udf_set) m_udf = 1;
    if (clr) begin mq.delete(); m_ovf = 0; m_udf = 0; end
    if (pv && !full && !clr) mq.push_back(pd);
    e_irq = m_en && (m_thr != 0) && (mq.size() >= int'(m_thr));
  endfunction

  task automatic drive(input bit r, input bit rq, input bit we, input logic [9:0] off,
                       input logic [31:0] wd, input logic [3:0] aid, input bit v,
                       input logic [31:0] d);
    rst       = r;
    req.req   = rq;
    req.we    = we;
    req.be    = 4'hF;
    req.addr  = UserMboxAddrOffset | {20'h0, off, 2'b00};
    req.wdata = wd;
    req.aid   = aid;
    pv        = v;
    pd        = d;
    set_comb_exp();
  endtask

  task automatic idle();
    drive(0, 0, 0, 10'd0, '0, '0, 0, '0);
  endtask

  task automatic cycle(input bit r, input bit rq, input bit we, input logic [9:0] off,
                       input logic [31:0] wd, input logic [3:0] aid, input bit v,
                       input logic [31:0] d);
    drive(r, rq, we, off, wd, aid, v, d);
    @(posedge clk);
    model_step();
    #1;
    idle();
  endtask

  task automatic rd(input logic [9:0] off, input logic [3:0] aid);
    cycle(0, 1, 0, off, '0, aid, 0, '0);
  endtask

  task automatic wr(input logic [9:0] off, input logic [31:0] wd);
    cycle(0, 1, 1, off, wd, 4'h3, 0, '0);
  endtask

  task automatic push(input logic [31:0] d);
    cycle(0, 0, 0, 10'd0, '0, '0, 1, d);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt", 32'(rsp.gnt), 32'(e_gnt));
      chk("push_ready", 32'(pr), 32'(e_rdy));
      chk("rvalid", 32'(rsp.rvalid), 32'(e_rvalid));
      if (e_rvalid) begin
        chk("rdata", rsp.rdata, e_rdata);
        chk("err", 32'(rsp.err), 32'(e_err));
        chk("rid", 32'(rsp.rid), e_rid);
      end
      chk("irq", 32'(irq), 32'(e_irq));
    end
  end

  initial begin
    idle();
    cycle(1, 0, 0, 10'd0, '0, '0, 0, '0);
    cycle(1, 0, 0, 10'd0, '0, '0, 0, '0);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_rvalid", 32'(rsp.rvalid), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_ready", 32'(pr), 32'h1);

    rd(10'd1, 4'h5);
    @(negedge clk);
    chk("status_after_reset", rsp.rdata, 32'h0000_0001);
    chk("status_rid", 32'(rsp.rid), 32'h5);
    chk("status_err", 32'(rsp.err), 32'h0);

    push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
    rd(10'd1, 4'h1); @(negedge clk); chk("level3", rsp.rdata, 32'h0000_0300);
    rd(10'd0, 4'h2); @(negedge clk); chk("pop_a", rsp.rdata, 32'hAAAA_0001);
    rd(10'd1, 4'h1); @(negedge clk); chk("level2", rsp.rdata, 32'h0000_0200);
    rd(10'd0, 4'h2); @(negedge clk); chk("pop_b", rsp.rdata, 32'hBBBB_0002);
    rd(10'd1, 4'h1); @(negedge clk); chk("level1", rsp.rdata, 32'h0000_0100);
    rd(10'd0, 4'h2); @(negedge clk); chk("pop_c", rsp.rdata, 32'hCCCC_0003);
    rd(10'd1, 4'h1); @(negedge clk); chk("level0", rsp.rdata, 32'h0000_0001);

    for (int i = 0; i < 9; i++) push(32'h0000_0900 + 32'(i));
    @(negedge clk);
    chk("full_ready_low", 32'(pr), 32'h0);
    rd(10'd1, 4'h7); @(negedge clk); chk("status_full_ovf", rsp.rdata, 32'h0000_0806);
    cycle(0, 1, 0, 10'd0, '0, 4'h8, 1, 32'h0000_0908);
    @(negedge clk);
    chk("pop_while_full", rsp.rdata, 32'h0000_0900);
    chk("ready_reasserts", 32'(pr), 32'h1);
    push(32'h0000_0908);
    for (int i = 0; i < 8; i++) rd(10'd0, 4'h9);
    @(negedge clk);
    chk("ninth_word", rsp.rdata, 32'h0000_0908);

    rd(10'd0, 4'hA); @(negedge clk);
    chk("underflow_rdata", rsp.rdata, 32'h0);
    chk("underflow_err", 32'(rsp.err), 32'h0);
    rd(10'd1, 4'hB); @(negedge clk); chk("status_udf_ovf", rsp.rdata, 32'h0000_000D);
    wr(10'd2, 32'h0000_0200);
    rd(10'd1, 4'hB); @(negedge clk); chk("status_cleared", rsp.rdata, 32'h0000_0001);

    wr(10'd2, 32'h0000_0103);
    push(32'h1); push(32'h2);
    @(negedge clk); chk("irq_below", 32'(irq), 32'h0);
    push(32'h3);
    @(negedge clk); chk("irq_at_thr", 32'(irq), 32'h1);
    rd(10'd0, 4'h1);
    @(negedge clk); chk("irq_after_pop", 32'(irq), 32'h0);
    rd(10'd2, 4'h1); @(negedge clk); chk("ctrl_readback", rsp.rdata, 32'h0000_0103);

    wr(10'd0, 32'hDEAD_BEEF); @(negedge clk); chk("wr_data_err", 32'(rsp.err), 32'h1);
    rd(10'd3, 4'h2); @(negedge clk);
    chk("bad_off_err", 32'(rsp.err), 32'h1);
    chk("bad_off_rdata", rsp.rdata, 32'h0);
    wr(10'd1, 32'hFFFF_FFFF); @(negedge clk); chk("wr_status_err", 32'(rsp.err), 32'h1);
    rd(10'd1, 4'h2); @(negedge clk); chk("status_unchanged", rsp.rdata, 32'h0000_0200);

    drive(0, 1, 1, 10'd2, 32'h0000_0200, 4'h4, 1, 32'h5555_5555);
    #1;
    chk("clear_ready_low", 32'(pr), 32'h0);
    @(posedge clk);
    model_step();
    #1;
    idle();
    rd(10'd1, 4'h2); @(negedge clk); chk("status_after_clear", rsp.rdata, 32'h0000_0001);

    push(32'h77); push(32'h78);
    cycle(1, 1, 0, 10'd1, '0, 4'h6, 0, '0);
    @(negedge clk); chk("reset_drops_rsp", 32'(rsp.rvalid), 32'h0);
    rd(10'd1, 4'h2); @(negedge clk); chk("status_after_rst", rsp.rdata, 32'h0000_0001);

    for (int k = 0; k < 3000; k++) begin
      bit          fill, rq, we, v, r;
      int          sel;
      logic [9:0]  off;
      logic [31:0] wd;
      fill = ((k / 250) % 2) == 0;
      rq   = fill ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      v    = fill ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      we   = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 9);
      off  = (sel < 5) ? 10'd0 : (sel < 7) ? 10'd1 : (sel < 9) ? 10'd2 : 10'($urandom);
      wd   = $urandom;
      wd[9]   = ($urandom_range(0, 15) == 0);
      wd[7:0] = 8'($urandom_range(0, 10));
      r    = ($urandom_range(0, 599) == 0);
      cycle(r, rq, we, off, wd, 4'($urandom), v, $urandom);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_mbox_rx.md
Name: user_mbox_rx

Overview:
- User-domain OBI subordinate behind the user-domain address demux, in its own 4 KiB window at UserBaseAddr + 32'h0000_1000.
- User logic pushes 32-bit words through a valid/ready stream port into a FIFO.
- The core pops them by reading a DATA register, and reads status and configures an interrupt threshold through STATUS and CTRL registers.

Parameters:
- Depth, 8, FIFO entries; power of two, at least 2.
- obi_req_t, croc_pkg::sbr_obi_req_t, OBI subordinate request type.
- obi_rsp_t, croc_pkg::sbr_obi_rsp_t, OBI subordinate response type.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- obi_req_i  in  obi_req_t  request fields: req, we, be, addr, wdata, aid.
- obi_rsp_o  out  obi_rsp_t  response fields: gnt, rvalid, rdata, err, rid.
- push_data_i  in  32  stream data from user logic.
- push_valid_i  in  1  stream valid.
- push_ready_o  out  1  stream ready.
- irq_o  out  1  level interrupt to the core.

Behaviour:
- Reset:
  - Only one clock; reset is synchronous and active-high. All state is cleared on the rising edge of clk_i while rst_i=1.
  - After reset: FIFO empty, level=0, sticky flags=0, CTRL=0, rvalid=0, rdata=0, err=0, rid=0, irq_o=0.
  - Reset mid-transaction drops the pending response; no rvalid follows.
- Bus handshake:
  - gnt = req, combinational; one transaction is accepted per cycle.
  - rvalid is asserted exactly 1 cycle after each grant. rdata, err and rid (= captured aid) are registered and valid together with rvalid.
  - Back-to-back grants produce back-to-back rvalid.
- Decode: word offset = addr[11:2]; be is ignored.
- 0x00 DATA:
  - Read pops the head word and returns it.
  - Read while empty returns 0, err=0, and sets sticky UNDERFLOW.
  - Write returns err=1 with no effect.
- 0x04 STATUS (read-only):
  - Fields: [0] empty, [1] full, [2] OVERFLOW sticky, [3] UNDERFLOW sticky, [15:8] level (zero-extended), all other bits 0.
  - Write returns err=1.
- 0x08 CTRL (read/write):
  - Fields: [7:0] threshold, [8] irq_en, [9] clear.
  - clear is write-only and self-clearing, and always reads as 0.
  - A write with clear=1 empties the FIFO and zeroes both sticky flags in the same cycle it is granted.
- Any other offset: err=1, rdata=0, no side effects.
- Stream port:
  - push_ready_o = !full && !(granted CTRL write with wdata[9]=1).
  - A push happens when valid && ready. push_valid_i high while full with no CTRL-clear write granted sets sticky OVERFLOW (sampled every such cycle).
  - Data is not lost by protocol: the producer holds it until ready.
- Simultaneous push and pop:
  - Both happen and level is unchanged.
  - Pop while empty never returns the word pushed in the same cycle; that word is visible from the next cycle. This is a read-under-empty underflow.
  - Push while full plus pop in the same cycle: push is not accepted, because ready is based on the registered full flag.
- Pointers and level:
  - Pointers wrap modulo Depth.
  - level is $clog2(Depth)+1 bits wide and ranges 0..Depth.
  - full = (level==Depth); empty = (level==0).
- Interrupt:
  - irq_o is registered: irq_o <= irq_en && threshold!=0 && level_next >= threshold.
  - Comparison is on level zero-extended to 8 bits.
  - A threshold greater than Depth never fires.

Decomposition:
- user_pkg additions:
  - UserMboxAddrOffset = croc_pkg::UserBaseAddr + 32'h1000, range 32'h1000.
  - Increment NumUserDomainSubordinates.
  - Add enum entry UserMbox and its addr_map rule.
  - Register offset localparams MboxDataOffset/MboxStatusOffset/MboxCtrlOffset.
- Sub-module user_mbox_fifo: synchronous FIFO with push/pop/flush and full/empty/level outputs.
- The OBI decode, response pipeline and interrupt logic live in user_mbox_rx.

Test Plan:
- Reset, then read STATUS → rvalid 1 cycle after gnt, rdata=32'h0000_0001 (empty), err=0; rid equals the issued aid.
- Push 3 words A,B,C; read DATA three times → A,B,C in order; STATUS level field goes 3,2,1,0.
- Depth=8: push 9 words continuously → ready drops after the 8th; OVERFLOW set; STATUS=32'h0000_0806; pop once → ready reasserts and the 9th word is accepted.
- Read DATA while empty → rdata=0, err=0, STATUS bit3=1. Then CTRL write 32'h200 → STATUS=32'h1, sticky flags cleared.
- CTRL=32'h103 (irq_en, threshold 3): push 2 → irq_o=0; push 3rd → irq_o=1 on the next cycle; pop one → irq_o=0 on the next cycle.
- Write to DATA, read 0x0C, write STATUS → each returns err=1 with FIFO state unchanged. Clear granted in the same cycle as push_valid → push_ready_o=0 and the FIFO ends empty.
